div_unit: RTL and testbench

Iterative 32-bit MIPS DIV/DIVU execute-stage unit. It accepts operands from the E stage, computes quotient (LO) and remainder (HI) with one restoring-division step per cycle, and drives `stall_div`. That signal feeds the hazard unit's `stall_divE` input, which holds the pipeline until the result is ready. It sits beside the ALU in E, upstream of the hazard unit and of the HI/LO register write.

---
 rtl/div_pkg.sv | 7 +
 rtl/div_step.sv | 17 +
 rtl/div_unit.sv | 125 ++++++++++++
 tb/tb_div_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative MIPS divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
  localparam int DIV_W = 32;
  localparam int DIV_CNT_W = $clog2(DIV_W);
  localparam logic [DIV_W-1:0] DIV_DZ_QUO = '1;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step; the compare path is one bit wider than the operands.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         msb,
  input  logic [W-1:0] dsr,
  output logic [W-1:0] rem_nxt,
  output logic         q
);
  logic [W:0] sh;
  logic [W:0] diff;
  assign sh      = {rem, msb};
  assign diff    = sh - {1'b0, dsr};
  assign q       = sh >= {1'b0, dsr};
  assign rem_nxt = q ? diff[W-1:0] : sh[W-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative DIV/DIVU for the E stage, one quotient bit per cycle.
// Define DIV_ZERO_FAST_EN to finish a zero-divisor divide in one cycle.
module div_unit
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              signed_div,
  input  logic              annul,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              stall_div,
  output logic              ready,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int CW = $clog2(DATA_W);
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_DZ = 1'b1;
`else
  localparam bit FAST_DZ = 1'b0;
`endif
  div_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] dvd_q, dvd_d, dsr_q, dsr_d, rem_q, rem_d, quo_q, quo_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [DATA_W-1:0] rem_s, a_abs, b_abs, quo_fin;
  logic              q_s, b_zero;
  div_step #(.W(DATA_W)) u_step (
    .rem    (rem_q),
    .msb    (dvd_q[DATA_W-1]),
    .dsr    (dsr_q),
    .rem_nxt(rem_s),
    .q      (q_s)
  );
  assign a_abs   = (signed_div && a[DATA_W-1]) ? -a : a;
  assign b_abs   = (signed_div && b[DATA_W-1]) ? -b : b;
  assign b_zero  = b == '0;
  assign quo_fin = {quo_q[DATA_W-2:0], q_s};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (start) begin
        if (FAST_DZ && b_zero) begin
          state_d = DONE;
          hi_d    = a;
          lo_d    = '1;
        end else begin
          state_d = BUSY;
          dvd_d   = b_zero ? a : a_abs;
          dsr_d   = b_abs;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          qneg_d  = signed_div & (a[DATA_W-1] ^ b[DATA_W-1]);
          rneg_d  = signed_div & a[DATA_W-1];
          dz_d    = b_zero;
        end
      end
      BUSY: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_s;
        quo_d = quo_fin;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d = DONE;
          hi_d    = (rneg_q && !dz_q) ? -rem_s : rem_s;
          lo_d    = (qneg_q && !dz_q) ? -quo_fin : quo_fin;
        end
      end
      default: state_d = IDLE;
    endcase
    // a killed instruction must leave HI/LO untouched, even on the final step
    if (annul) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign stall_div = (state_q == IDLE && start && !annul) || state_q == BUSY;
  assign ready     = state_q == DONE;
  assign hi        = hi_q;
  assign lo        = lo_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed divides; a negedge monitor checks every ready pulse against a queue.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        stall_div, ready;
  logic [31:0] hi, lo;
  logic [63:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
`ifdef DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  div_unit dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .signed_div(signed_div),
    .annul     (annul),
    .a         (a),
    .b         (b),
    .stall_div (stall_div),
    .ready     (ready),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_ready: hi=%h lo=%h with no result pending", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          n_bad++;
          $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic run(input string name, input logic sgn, input logic [31:0] da, input logic [31:0] db,
                     input logic [31:0] elo, input logic [31:0] ehi, input int lat);
    int k;
    int st;
    exp_q.push_back({ehi, elo});
    @(posedge clk);
    #1;
    start = 1'b1;
    signed_div = sgn;
    a = da;
    b = db;
    st = 0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready) break;
      if (stall_div) st++;
    end
    chk({name, "_latency"}, k, lat);
    chk({name, "_stall_cycles"}, st, lat);
    chk({name, "_stall_in_ready"}, 32'(stall_div), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_stall", 32'(stall_div), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    run("divu_max_2", 1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 33);
    run("div_m1_2", 1'b1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 33);
    run("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33);
    // annul at T+10: nothing completes and HI/LO keep the last result
    @(posedge clk);
    #1;
    start = 1'b1;
    signed_div = 1'b0;
    a = 32'd100;
    b = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    @(negedge clk);
    chk("annul_stall", 32'(stall_div), 32'd0);
    repeat (40) @(negedge clk);
    chk("annul_hi", hi, 32'd0);
    chk("annul_lo", lo, 32'h80000000);
    run("div_by_zero", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, DZ_LAT);
    run("divu_back2back", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33);
    // asynchronous reset in the middle of a divide
    @(posedge clk);
    #1;
    start = 1'b1;
    a = 32'd77;
    b = 32'd5;
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_mid_stall", 32'(stall_div), 32'd0);
    repeat (40) @(negedge clk);
    chk("pending_results", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
